// File: rtl/apb_ram_ws_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_ram_ws_if
// Description : APB bus bundle between an APB master and the apb_ram_ws slave
//               memory. With APB_RAM_PSTRB_EN defined the bundle also carries
//               the byte write strobe PSTRB.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_ram_ws_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_RAM_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PSLVERR;

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
`ifdef APB_RAM_PSTRB_EN
    output PSTRB,
`endif
    input  PREADY,
    input  PRDATA,
    input  PSLVERR
  );

  modport slave (
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
`ifdef APB_RAM_PSTRB_EN
    input  PSTRB,
`endif
    output PREADY,
    output PRDATA,
    output PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/apb_ram_ws.sv
`default_nettype none
// ============================================================================
// Module      : apb_ram_ws
// Description : Parametrised APB slave memory, word addressed, with a
//               configurable number of access-phase wait states. Addresses at
//               or above DEPTH complete with PSLVERR=1 and never touch memory.
//               An access phase dropped while waiting aborts the transfer.
//               Optional macro APB_RAM_PSTRB_EN adds byte write strobes
//               (PSTRB); a read with any strobe bit set is an error.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_ram_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 200,
  parameter int WAIT_STATES = 0
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb_ram_ws_if.slave  bus
);

  localparam int                  C_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                  C_NBYTES    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] C_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          C_WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit                  C_NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_wait_cnt;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_xfer;
  logic                  w_access;
  logic                  w_in_range;
  logic                  w_rd_strb_err;
  logic                  w_err;
  logic                  w_mem_we;
  logic [C_NBYTES-1:0]   w_byte_en;
  logic [C_IDX_W-1:0]    w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_xfer     = bus.PSEL & bus.PENABLE;
  assign w_in_range = ({1'b0, bus.PADDR} < C_DEPTH_EXT);
  assign w_idx      = bus.PADDR[C_IDX_W-1:0];
  assign w_rd_word  = r_mem[w_idx];

`ifdef APB_RAM_PSTRB_EN
  assign w_byte_en     = bus.PSTRB;
  assign w_rd_strb_err = |bus.PSTRB;
`else
  assign w_byte_en     = '1;
  assign w_rd_strb_err = 1'b0;
`endif

  // Out-of-range address, or a read carrying write strobes, is an error.
  assign w_err = ~w_in_range | (~bus.PWRITE & w_rd_strb_err);

  // The edge that performs the access is the one that raises PREADY; reset
  // on the same edge suppresses it.
  assign w_access = ~PRESET & w_xfer &
                    (((r_state == ST_IDLE) & C_NO_WAIT) |
                     ((r_state == ST_WAIT) & (r_wait_cnt == 4'd0)));

  assign w_mem_we = w_access & bus.PWRITE & ~w_err;

  // Transfer FSM with registered PREADY/PSLVERR/PRDATA.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_state   <= ST_RESP;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            if (!bus.PWRITE) r_prdata <= w_err ? '0 : w_rd_word;
          end else if (w_xfer) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= C_WS_LOAD;
          end
        end
        ST_WAIT: begin
          if (!w_xfer) begin
            // Master left the access phase early: abandon without writing.
            r_state <= ST_IDLE;
          end else if (w_access) begin
            r_state   <= ST_RESP;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            if (!bus.PWRITE) r_prdata <= w_err ? '0 : w_rd_word;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state   <= ST_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane memory write; contents are deliberately not reset.
  always_ff @(posedge PCLK) begin
    if (w_mem_we) begin
      for (int b = 0; b < C_NBYTES; b++) begin
        if (w_byte_en[b]) r_mem[w_idx][8*b +: 8] <= bus.PWDATA[8*b +: 8];
      end
    end
  end

  assign bus.PREADY  = r_pready;
  assign bus.PSLVERR = r_pslverr;
  assign bus.PRDATA  = r_prdata;

endmodule
`default_nettype wire
